// File: rtl/sdram_burst_read.sv
// Single-bank SDRAM read engine: ACTIVE, one READ burst, streamed words plus
// a wide assembled result. Pin outputs float when the arbiter withdraws ienb.
module sdram_burst_read #(
  parameter int BURST_LEN = 8,
  parameter int CAS_LAT   = 2,
  parameter int T_RCD     = 2,
  parameter int AUTO_PRE  = 1,
  parameter int DQ_W      = 16,
  parameter int ROW_W     = 13,
  parameter int COL_W     = 10
) (
  input  logic                      iclk,
  input  logic                      ireset_n,
  input  logic                      ireq,
  input  logic                      ienb,
  output logic                      obusy,
  output logic                      ofin,
  input  logic [ROW_W-1:0]          irow,
  input  logic [COL_W-1:0]          icolumn,
  input  logic [1:0]                ibank,
  output logic [DQ_W-1:0]           oword,
  output logic                      oword_valid,
  output logic [BURST_LEN*DQ_W-1:0] odata,
  output logic                      DRAM_CLK,
  output logic                      DRAM_CKE,
  output logic [12:0]               DRAM_ADDR,
  output logic [1:0]                DRAM_BA,
  output logic                      DRAM_CS_N,
  output logic                      DRAM_RAS_N,
  output logic                      DRAM_CAS_N,
  output logic                      DRAM_WE_N,
  output logic                      DRAM_LDQM,
  output logic                      DRAM_UDQM,
  input  logic [DQ_W-1:0]           DRAM_DQ
);

  if (!(BURST_LEN == 1 || BURST_LEN == 2 || BURST_LEN == 4 || BURST_LEN == 8)) begin : g_bad_burst
    $error("sdram_burst_read: BURST_LEN must be 1, 2, 4 or 8");
  end
  if (!(CAS_LAT == 2 || CAS_LAT == 3)) begin : g_bad_cas
    $error("sdram_burst_read: CAS_LAT must be 2 or 3");
  end
  if (T_RCD < 1) begin : g_bad_trcd
    $error("sdram_burst_read: T_RCD must be at least 1");
  end
  if (COL_W > 10 || ROW_W > 13) begin : g_bad_addr
    $error("sdram_burst_read: COL_W must be <= 10 and ROW_W <= 13");
  end

  localparam int CNT_M1  = (T_RCD > BURST_LEN) ? T_RCD : BURST_LEN;
  localparam int CNT_MAX = (CNT_M1 > CAS_LAT) ? CNT_M1 : CAS_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int REL_W   = $clog2(CAS_LAT + BURST_LEN + 2);
  localparam logic AP_BIT = (AUTO_PRE != 0);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_READ = 4'b0101;

  typedef enum logic [2:0] {IDLE, ACT, TRCD, RD, CASW, CAPT, FIN} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [REL_W-1:0] rel_reg;
  logic [COL_W-1:0] col_reg;
  logic [1:0]       bank_reg;
  logic [3:0]       cmd_reg;
  logic [12:0]      addr_reg;
  logic [1:0]       ba_reg;
  logic [1:0]       dqm_reg;
  logic             read_now;

  // DQM for the pin cycle that sits r cycles after the READ command.
  function automatic logic [1:0] dqm_for(input int r);
    return (r >= CAS_LAT - 2 && r <= CAS_LAT + BURST_LEN - 3) ? 2'b00 : 2'b11;
  endfunction

  // Last cycle before READ goes on the pins; with T_RCD=1 that is the ACTIVE cycle.
  assign read_now = (state_reg == ACT && T_RCD == 1) ||
                    (state_reg == TRCD && cnt_reg == CNT_W'(T_RCD - 1));

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      rel_reg     <= '0;
      col_reg     <= '0;
      bank_reg    <= '0;
      cmd_reg     <= CMD_NOP;
      addr_reg    <= '0;
      ba_reg      <= '0;
      dqm_reg     <= 2'b11;
      obusy       <= 1'b0;
      ofin        <= 1'b0;
      oword       <= '0;
      oword_valid <= 1'b0;
      odata       <= '0;
    end else begin
      cmd_reg     <= CMD_NOP;
      dqm_reg     <= 2'b11;
      oword_valid <= 1'b0;
      ofin        <= 1'b0;
      if (read_now) begin
        cmd_reg   <= CMD_READ;
        addr_reg  <= {2'b00, AP_BIT, 10'(col_reg)};
        ba_reg    <= bank_reg;
        rel_reg   <= '0;
        dqm_reg   <= dqm_for(0);
        cnt_reg   <= '0;
        state_reg <= RD;
      end else begin
        case (state_reg)
          IDLE: begin
            if (ireq) begin
              col_reg   <= icolumn;
              bank_reg  <= ibank;
              cmd_reg   <= CMD_ACT;
              addr_reg  <= 13'(irow);
              ba_reg    <= ibank;
              obusy     <= 1'b1;
              state_reg <= ACT;
            end
          end
          ACT: begin
            cnt_reg   <= CNT_W'(1);
            state_reg <= TRCD;
          end
          TRCD: cnt_reg <= cnt_reg + 1'b1;
          RD: begin
            rel_reg   <= rel_reg + 1'b1;
            dqm_reg   <= dqm_for(1);
            cnt_reg   <= CNT_W'(1);
            state_reg <= CASW;
          end
          CASW: begin
            rel_reg <= rel_reg + 1'b1;
            dqm_reg <= dqm_for(int'(rel_reg) + 1);
            if (cnt_reg == CNT_W'(CAS_LAT - 1)) begin
              cnt_reg   <= '0;
              state_reg <= CAPT;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          CAPT: begin
            rel_reg <= rel_reg + 1'b1;
            dqm_reg <= dqm_for(int'(rel_reg) + 1);
            // The extra pass with cnt==BURST_LEN presents the last word before ofin.
            if (cnt_reg == CNT_W'(BURST_LEN)) begin
              cnt_reg   <= '0;
              ofin      <= 1'b1;
              state_reg <= FIN;
            end else begin
              oword       <= DRAM_DQ;
              oword_valid <= 1'b1;
              odata[(BURST_LEN - 1 - int'(cnt_reg)) * DQ_W +: DQ_W] <= DRAM_DQ;
              cnt_reg     <= cnt_reg + 1'b1;
            end
          end
          FIN: begin
            obusy     <= 1'b0;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign DRAM_CLK   = ienb ? ~iclk       : 1'bz;
  assign DRAM_CKE   = ienb ? 1'b1        : 1'bz;
  assign DRAM_ADDR  = ienb ? addr_reg    : 13'bz;
  assign DRAM_BA    = ienb ? ba_reg      : 2'bz;
  assign DRAM_CS_N  = ienb ? cmd_reg[3]  : 1'bz;
  assign DRAM_RAS_N = ienb ? cmd_reg[2]  : 1'bz;
  assign DRAM_CAS_N = ienb ? cmd_reg[1]  : 1'bz;
  assign DRAM_WE_N  = ienb ? cmd_reg[0]  : 1'bz;
  assign DRAM_LDQM  = ienb ? dqm_reg[1]  : 1'bz;
  assign DRAM_UDQM  = ienb ? dqm_reg[0]  : 1'bz;

endmodule

// File: tb/tb_sdram_burst_read.sv
// Bench for sdram_burst_read: three parameter sets checked cycle by cycle
// against a latency/timeline model, with an SDRAM data model per instance.
module tb_sdram_burst_read;
  localparam int ND = 3;
  localparam int TR_P [ND] = '{2, 1, 1};
  localparam int CL_P [ND] = '{2, 3, 2};
  localparam int BL_P [ND] = '{8, 4, 1};
  localparam int AP_P [ND] = '{1, 0, 1};
  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] ACTV = 4'b0011;
  localparam logic [3:0] READ = 4'b0101;

  logic iclk = 1'b0;
  always #5 iclk = ~iclk;

  logic        ireset_n;
  logic        ienb;
  logic        oth_en;
  logic [22:0] oth_val;
  logic        ireq [ND];
  logic [12:0] irow;
  logic [9:0]  icolumn;
  logic [1:0]  ibank;
  logic [15:0] wbase [ND];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // bus view: [22] clk [21] cke [20:17] cmd [16:15] dqm [14:13] ba [12:0] addr
  wire [22:0]  obs_bus   [ND];
  wire         obs_busy  [ND];
  wire         obs_fin   [ND];
  wire         obs_wv    [ND];
  wire [15:0]  obs_word  [ND];
  wire [127:0] obs_odata [ND];

  always @(posedge iclk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    localparam int BL = BL_P[gi];
    wire        dclk, dcke, cs_n, ras_n, cas_n, we_n, ldqm, udqm;
    wire [1:0]  ba;
    wire [12:0] addr;
    logic       busy, fin, wv;
    logic [15:0] word;
    logic [BL*16-1:0] odata;
    logic [15:0] dq;
    int          rd_cyc = -100;

    sdram_burst_read #(
      .BURST_LEN(BL), .CAS_LAT(CL_P[gi]), .T_RCD(TR_P[gi]), .AUTO_PRE(AP_P[gi]),
      .DQ_W(16), .ROW_W(13), .COL_W(10)
    ) u_dut (
      .iclk(iclk), .ireset_n(ireset_n), .ireq(ireq[gi]), .ienb(ienb),
      .obusy(busy), .ofin(fin), .irow(irow), .icolumn(icolumn), .ibank(ibank),
      .oword(word), .oword_valid(wv), .odata(odata),
      .DRAM_CLK(dclk), .DRAM_CKE(dcke), .DRAM_ADDR(addr), .DRAM_BA(ba),
      .DRAM_CS_N(cs_n), .DRAM_RAS_N(ras_n), .DRAM_CAS_N(cas_n), .DRAM_WE_N(we_n),
      .DRAM_LDQM(ldqm), .DRAM_UDQM(udqm), .DRAM_DQ(dq)
    );

    // another engine sharing the pin bus
    assign dclk  = oth_en ? oth_val[22]    : 1'bz;
    assign dcke  = oth_en ? oth_val[21]    : 1'bz;
    assign cs_n  = oth_en ? oth_val[20]    : 1'bz;
    assign ras_n = oth_en ? oth_val[19]    : 1'bz;
    assign cas_n = oth_en ? oth_val[18]    : 1'bz;
    assign we_n  = oth_en ? oth_val[17]    : 1'bz;
    assign ldqm  = oth_en ? oth_val[16]    : 1'bz;
    assign udqm  = oth_en ? oth_val[15]    : 1'bz;
    assign ba    = oth_en ? oth_val[14:13] : 2'bz;
    assign addr  = oth_en ? oth_val[12:0]  : 13'bz;

    assign obs_bus[gi]   = {dclk, dcke, cs_n, ras_n, cas_n, we_n, ldqm, udqm, ba, addr};
    assign obs_busy[gi]  = busy;
    assign obs_fin[gi]   = fin;
    assign obs_wv[gi]    = wv;
    assign obs_word[gi]  = word;
    assign obs_odata[gi] = 128'(odata);

    // SDRAM model: word k is on DQ during pin cycle READ+CAS+k, junk otherwise
    always @(negedge iclk) begin
      int k;
      if ({cs_n, ras_n, cas_n, we_n} == READ) rd_cyc = cyc;
      k = cyc - rd_cyc - CL_P[gi];
      dq = (k >= 0 && k < BL) ? wbase[gi] + 16'(k) : 16'($urandom);
    end
  end

  // Entry/exit: just after the negedge of an idle cycle whose ending edge accepts.
  task automatic do_transfer(input int d, input logic [12:0] row, input logic [9:0] col,
                             input logic [1:0] bank, input logic [15:0] base,
                             input bit noise, input bit hold);
    int r, cl, bl, nfin, last;
    logic [127:0] exp_data;
    logic [3:0]  exp_cmd;
    logic [1:0]  exp_dqm;
    logic        exp_wv;
    r = 1 + TR_P[d]; cl = CL_P[d]; bl = BL_P[d];
    nfin = r + cl + bl + 1;
    last = nfin + (hold ? 1 : 2);
    wbase[d] = base;
    irow = row; icolumn = col; ibank = bank; ireq[d] = 1'b1;
    exp_data = '0;
    for (int j = 0; j < bl; j++) exp_data[(bl - 1 - j) * 16 +: 16] = base + 16'(j);
    for (int n = 1; n <= last; n++) begin
      @(negedge iclk);
      exp_cmd = (n == 1) ? ACTV : (n == r) ? READ : NOP;
      exp_dqm = (n >= r + cl - 2 && n <= r + cl + bl - 3) ? 2'b00 : 2'b11;
      exp_wv  = (n >= r + cl + 1 && n <= r + cl + bl);
      checks++;
      if (obs_bus[d][20:17] !== exp_cmd) begin
        errors++; $display("FAIL cmd dut%0d n=%0d: got %b want %b", d, n, obs_bus[d][20:17], exp_cmd);
      end
      checks++;
      if (obs_bus[d][16:15] !== exp_dqm) begin
        errors++; $display("FAIL dqm dut%0d n=%0d: got %b want %b", d, n, obs_bus[d][16:15], exp_dqm);
      end
      if (n == 1) begin
        checks++;
        if (obs_bus[d][12:0] !== row || obs_bus[d][14:13] !== bank) begin
          errors++; $display("FAIL act_addr dut%0d: got %h/%0d want %h/%0d", d, obs_bus[d][12:0], obs_bus[d][14:13], row, bank);
        end
      end
      if (n == r) begin
        checks++;
        if (obs_bus[d][12:0] !== {2'b00, 1'(AP_P[d]), col} || obs_bus[d][14:13] !== bank) begin
          errors++; $display("FAIL rd_addr dut%0d: got %h/%0d want %h/%0d", d, obs_bus[d][12:0], obs_bus[d][14:13], {2'b00, 1'(AP_P[d]), col}, bank);
        end
      end
      checks++;
      if (obs_wv[d] !== exp_wv) begin
        errors++; $display("FAIL word_valid dut%0d n=%0d: got %b want %b", d, n, obs_wv[d], exp_wv);
      end
      if (exp_wv) begin
        checks++;
        if (obs_word[d] !== base + 16'(n - r - cl - 1)) begin
          errors++; $display("FAIL word dut%0d n=%0d: got %h want %h", d, n, obs_word[d], base + 16'(n - r - cl - 1));
        end
      end
      checks++;
      if (obs_fin[d] !== (n == nfin) || obs_busy[d] !== (n <= nfin)) begin
        errors++; $display("FAIL fin_busy dut%0d n=%0d: got %b%b want %b%b", d, n, obs_fin[d], obs_busy[d], n == nfin, n <= nfin);
      end
      if (n == nfin) begin
        checks++;
        if (obs_odata[d] !== exp_data) begin
          errors++; $display("FAIL odata dut%0d: got %h want %h", d, obs_odata[d], exp_data);
        end
      end
      if (noise) begin
        irow = 13'($urandom); icolumn = 10'($urandom); ibank = 2'($urandom);
      end
      if (hold) ireq[d] = 1'b1;
      else ireq[d] = (noise && n < nfin) ? 1'($urandom) : 1'b0;
    end
  endtask

  function automatic logic [9:0] rand_col(input int d);
    return 10'($urandom) & ~10'(BL_P[d] - 1);
  endfunction

  task automatic test_reset;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (obs_bus[d][21:0] !== {1'b1, NOP, 2'b11, 15'h0}) begin
        errors++; $display("FAIL reset_pins dut%0d: got %h want %h", d, obs_bus[d][21:0], {1'b1, NOP, 2'b11, 15'h0});
      end
      checks++;
      if ({obs_busy[d], obs_fin[d], obs_wv[d], obs_word[d]} !== 19'h0 || obs_odata[d] !== 128'h0) begin
        errors++; $display("FAIL reset_outs dut%0d: got %b%b%b %h %h want zeros", d, obs_busy[d], obs_fin[d], obs_wv[d], obs_word[d], obs_odata[d]);
      end
    end
    @(negedge iclk);
    ireset_n = 1'b1;
  endtask

  task automatic test_default;
    do_transfer(0, 13'h0123, 10'h008, 2'd2, 16'h1000, 1'b0, 1'b0);
    for (int t = 0; t < 3; t++)
      do_transfer(0, 13'($urandom), rand_col(0), 2'($urandom), 16'($urandom), 1'b1, 1'b0);
  endtask

  task automatic test_bl4_cas3;
    for (int t = 0; t < 3; t++)
      do_transfer(1, 13'($urandom), rand_col(1), 2'($urandom), 16'($urandom), t != 0, 1'b0);
  endtask

  task automatic test_trcd1_bl1;
    for (int t = 0; t < 3; t++)
      do_transfer(2, 13'($urandom), rand_col(2), 2'($urandom), 16'($urandom), t != 0, 1'b0);
  endtask

  task automatic test_back_to_back;
    do_transfer(0, 13'($urandom), rand_col(0), 2'($urandom), 16'($urandom), 1'b0, 1'b1);
    do_transfer(0, 13'($urandom), rand_col(0), 2'($urandom), 16'($urandom), 1'b0, 1'b1);
    do_transfer(0, 13'($urandom), rand_col(0), 2'($urandom), 16'($urandom), 1'b0, 1'b0);
    do_transfer(1, 13'($urandom), rand_col(1), 2'($urandom), 16'($urandom), 1'b0, 1'b1);
    do_transfer(1, 13'($urandom), rand_col(1), 2'($urandom), 16'($urandom), 1'b0, 1'b0);
  endtask

  task automatic test_ienb;
    logic [22:0] pat;
    ienb = 1'b0;
    oth_en = 1'b1;
    pat = 23'($urandom);
    for (int p = 0; p < 2; p++) begin
      oth_val = (p == 0) ? pat : ~pat;
      #1;
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (obs_bus[d] !== oth_val) begin
          errors++; $display("FAIL hiz dut%0d: got %h want %h", d, obs_bus[d], oth_val);
        end
      end
    end
    oth_en = 1'b0;
    ienb = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (obs_bus[d][22:15] !== {~iclk, 1'b1, NOP, 2'b11}) begin
        errors++; $display("FAIL enb_pins dut%0d: got %b want %b", d, obs_bus[d][22:15], {~iclk, 1'b1, NOP, 2'b11});
      end
    end
  endtask

  task automatic test_reset_abort;
    int stop;
    stop = 1 + TR_P[0] + CL_P[0] + 3;
    wbase[0] = 16'($urandom);
    irow = 13'($urandom); icolumn = rand_col(0); ibank = 2'($urandom);
    ireq[0] = 1'b1;
    for (int n = 1; n <= stop; n++) begin
      @(negedge iclk);
      ireq[0] = 1'b0;
    end
    checks++;
    if (obs_wv[0] !== 1'b1 || obs_word[0] !== wbase[0] + 16'd2) begin
      errors++; $display("FAIL pre_abort: got %b %h want 1 %h", obs_wv[0], obs_word[0], wbase[0] + 16'd2);
    end
    #2 ireset_n = 1'b0;
    #1;
    checks++;
    if (obs_bus[0][21:0] !== {1'b1, NOP, 2'b11, 15'h0}) begin
      errors++; $display("FAIL abort_pins: got %h want %h", obs_bus[0][21:0], {1'b1, NOP, 2'b11, 15'h0});
    end
    checks++;
    if ({obs_busy[0], obs_fin[0], obs_wv[0], obs_word[0]} !== 19'h0 || obs_odata[0] !== 128'h0) begin
      errors++; $display("FAIL abort_outs: got %b%b%b %h %h want zeros", obs_busy[0], obs_fin[0], obs_wv[0], obs_word[0], obs_odata[0]);
    end
    for (int n = 0; n < 14; n++) begin
      @(negedge iclk);
      if (n == 1) ireset_n = 1'b1;
      checks++;
      if (obs_fin[0] !== 1'b0 || obs_bus[0][20:17] !== NOP) begin
        errors++; $display("FAIL post_abort n=%0d: got fin %b cmd %b want 0 %b", n, obs_fin[0], obs_bus[0][20:17], NOP);
      end
    end
    do_transfer(0, 13'($urandom), rand_col(0), 2'($urandom), 16'($urandom), 1'b1, 1'b0);
  endtask

  initial begin
    ireset_n = 1'b0;
    ienb = 1'b1;
    oth_en = 1'b0;
    oth_val = '0;
    irow = '0; icolumn = '0; ibank = '0;
    for (int d = 0; d < ND; d++) begin
      ireq[d] = 1'b0;
      wbase[d] = '0;
    end
    #12;
    test_reset;
    test_default;
    test_bl4_cas3;
    test_trcd1_bl1;
    test_back_to_back;
    test_ienb;
    test_reset_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
